// File: rtl/jtag_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encoding and opcode constants sized by IR width.
package jtag_pkg;

    localparam int unsigned TAP_STATE_W = 4;
    localparam int unsigned IDCODE_W    = 32;

    typedef enum logic [TAP_STATE_W-1:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_IDLE         = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    // All-ones mask for an instruction register of width ir_w (ir_w <= 31).
    function automatic logic [31:0] ir_mask(input int unsigned ir_w);
        return (32'h1 << ir_w) - 32'h1;
    endfunction

    function automatic logic [31:0] op_extest(input int unsigned ir_w);
        return ir_mask(ir_w) & 32'h0;
    endfunction

    function automatic logic [31:0] op_sample(input int unsigned ir_w);
        return ir_mask(ir_w) & 32'h1;
    endfunction

    function automatic logic [31:0] op_idcode(input int unsigned ir_w);
        return ir_mask(ir_w) & 32'h2;
    endfunction

    function automatic logic [31:0] op_bypass(input int unsigned ir_w);
        return ir_mask(ir_w);
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller; TRST low at a TCLK edge forces Test-Logic-Reset.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic                   TCLK,
    input  logic                   TRST,
    input  logic                   TMS,
    output logic [TAP_STATE_W-1:0] tap_state
);

    tap_state_e state_q;
    tap_state_e state_d;

    always_ff @(posedge TCLK) begin
        if (!TRST) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TEST_LOGIC_RESET: state_d = TMS ? TEST_LOGIC_RESET : RUN_IDLE;
            RUN_IDLE:         state_d = TMS ? SELECT_DR        : RUN_IDLE;
            SELECT_DR:        state_d = TMS ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       state_d = TMS ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = TMS ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = TMS ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = TMS ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = TMS ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = TMS ? SELECT_DR        : RUN_IDLE;
            SELECT_IR:        state_d = TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = TMS ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = TMS ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = TMS ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = TMS ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = TMS ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = TMS ? SELECT_DR        : RUN_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    assign tap_state = state_q;

endmodule

// File: rtl/jtag_tap_param.sv
// JTAG TAP with IR, bypass, optional IDCODE and external BSR strobes.
// Define JTAG_IDCODE_EN to include the 32-bit IDCODE register (reset instruction becomes IDCODE).
module jtag_tap_param
    import jtag_pkg::*;
#(
    parameter int unsigned IR_W       = 4,
    parameter int unsigned BSR_LEN    = 36,
    parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
    input  logic                   TCLK,
    input  logic                   TRST,
    input  logic                   TMS,
    input  logic                   TDI,
    output logic                   TDO,
    output logic                   tdo_en,
    input  logic                   bsr_tdo,
    output logic                   bsr_capture,
    output logic                   bsr_shift,
    output logic                   bsr_update,
    output logic                   bsr_mode,
    output logic [IR_W-1:0]        ir_out,
    output logic [TAP_STATE_W-1:0] tap_state
);

    if (IR_W < 2) begin : g_ir_w_chk
        $error("jtag_tap_param: IR_W must be at least 2");
    end
    if (IDCODE_VAL[0] != 1'b1) begin : g_idcode_chk
        $error("jtag_tap_param: IDCODE_VAL bit 0 must be 1");
    end
    if (BSR_LEN == 0) begin : g_bsr_chk
        $error("jtag_tap_param: BSR_LEN must be nonzero");
    end

    localparam logic [IR_W-1:0] OP_EXTEST = IR_W'(op_extest(IR_W));
    localparam logic [IR_W-1:0] OP_SAMPLE = IR_W'(op_sample(IR_W));
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(op_idcode(IR_W));
    localparam logic [IR_W-1:0] RESET_IR  = OP_IDCODE;
`else
    localparam logic [IR_W-1:0] RESET_IR  = IR_W'(op_bypass(IR_W));
`endif

    tap_state_e      st;
    logic [IR_W-1:0] ir_sr;
    logic [IR_W-1:0] ir_q;
    logic            bypass_q;
    logic            sel_extest_c;
    logic            sel_bsr_c;
    logic            sel_idcode_c;
    logic            idcode_lsb_c;

    jtag_tap_fsm u_fsm (
        .TCLK      (TCLK),
        .TRST      (TRST),
        .TMS       (TMS),
        .tap_state (tap_state)
    );

    assign st = tap_state_e'(tap_state);

    assign sel_extest_c = (ir_q == OP_EXTEST);
    assign sel_bsr_c    = sel_extest_c || (ir_q == OP_SAMPLE);

`ifdef JTAG_IDCODE_EN
    logic [IDCODE_W-1:0] idcode_q;

    assign sel_idcode_c = (ir_q == OP_IDCODE);
    assign idcode_lsb_c = idcode_q[0];

    always_ff @(posedge TCLK) begin
        if (!TRST) begin
            idcode_q <= IDCODE_VAL;
        end else if (st == CAPTURE_DR) begin
            idcode_q <= IDCODE_VAL;
        end else if (st == SHIFT_DR && sel_idcode_c) begin
            idcode_q <= {TDI, idcode_q[IDCODE_W-1:1]};
        end
    end
`else
    assign sel_idcode_c = 1'b0;
    assign idcode_lsb_c = 1'b0;
`endif

    // IR shift stage and active instruction; leaving Select-IR with TMS=1 enters reset.
    always_ff @(posedge TCLK) begin
        if (!TRST) begin
            ir_sr <= '0;
            ir_q  <= RESET_IR;
        end else begin
            case (st)
                CAPTURE_IR:       ir_sr <= IR_W'(2'b01);
                SHIFT_IR:         ir_sr <= {TDI, ir_sr[IR_W-1:1]};
                UPDATE_IR:        ir_q  <= ir_sr;
                TEST_LOGIC_RESET: ir_q  <= RESET_IR;
                SELECT_IR:        if (TMS) ir_q <= RESET_IR;
                default:          ;
            endcase
        end
    end

    // Bypass is the default DR for every opcode not claimed by BSR or IDCODE.
    always_ff @(posedge TCLK) begin
        if (!TRST) begin
            bypass_q <= 1'b0;
        end else if (st == CAPTURE_DR) begin
            bypass_q <= 1'b0;
        end else if (st == SHIFT_DR && !sel_bsr_c && !sel_idcode_c) begin
            bypass_q <= TDI;
        end
    end

    always_comb begin
        tdo_en      = 1'b0;
        TDO         = 1'b0;
        bsr_capture = 1'b0;
        bsr_shift   = 1'b0;
        bsr_update  = 1'b0;
        case (st)
            SHIFT_IR: begin
                tdo_en = 1'b1;
                TDO    = ir_sr[0];
            end
            SHIFT_DR: begin
                tdo_en    = 1'b1;
                bsr_shift = sel_bsr_c;
                if (sel_bsr_c)         TDO = bsr_tdo;
                else if (sel_idcode_c) TDO = idcode_lsb_c;
                else                   TDO = bypass_q;
            end
            CAPTURE_DR: bsr_capture = sel_bsr_c;
            UPDATE_DR:  bsr_update  = sel_bsr_c;
            default:    ;
        endcase
    end

    assign bsr_mode = sel_extest_c;
    assign ir_out   = ir_q;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Directed bench for jtag_tap_param: stimulus queues expected TDO bits, a monitor checks them.
// Honours JTAG_IDCODE_EN the same way the design does.
module tb_jtag_tap_param;

    localparam int unsigned IR_W       = 4;
    localparam int unsigned BSR_LEN    = 36;
    localparam logic [31:0] IDCODE_VAL = 32'h0000_0001;
    localparam logic [63:0] CAP_PAT    = 64'h0000_0009_A5C3_F00F;
`ifdef JTAG_IDCODE_EN
    localparam logic [3:0]  RESET_IR   = 4'h2;
`else
    localparam logic [3:0]  RESET_IR   = 4'hF;
`endif

    logic             TCLK;
    logic             TRST;
    logic             TMS;
    logic             TDI;
    logic             TDO;
    logic             tdo_en;
    logic             bsr_tdo;
    logic             bsr_capture;
    logic             bsr_shift;
    logic             bsr_update;
    logic             bsr_mode;
    logic [IR_W-1:0]  ir_out;
    logic [3:0]       tap_state;

    logic [BSR_LEN-1:0] bsr_chain;
    logic               exp_q[$];
    int                 n_tests = 0;
    int                 n_fail  = 0;
    int                 cap_cnt = 0;
    int                 shf_cnt = 0;
    int                 upd_cnt = 0;
    int                 tdo_idx = 0;

    jtag_tap_param #(
        .IR_W       (IR_W),
        .BSR_LEN    (BSR_LEN),
        .IDCODE_VAL (IDCODE_VAL)
    ) dut (
        .TCLK        (TCLK),
        .TRST        (TRST),
        .TMS         (TMS),
        .TDI         (TDI),
        .TDO         (TDO),
        .tdo_en      (tdo_en),
        .bsr_tdo     (bsr_tdo),
        .bsr_capture (bsr_capture),
        .bsr_shift   (bsr_shift),
        .bsr_update  (bsr_update),
        .bsr_mode    (bsr_mode),
        .ir_out      (ir_out),
        .tap_state   (tap_state)
    );

    initial TCLK = 1'b0;
    always #5 TCLK = ~TCLK;

    // External boundary-scan chain model
    always @(posedge TCLK) begin
        if (bsr_capture)    bsr_chain <= CAP_PAT[BSR_LEN-1:0];
        else if (bsr_shift) bsr_chain <= {TDI, bsr_chain[BSR_LEN-1:1]};
    end
    assign bsr_tdo = bsr_chain[0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCLK);
        #1;
    endtask

    // From Run-Test/Idle: load op into IR and return to Run-Test/Idle.
    task automatic shift_ir(input logic [IR_W-1:0] op);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("state_shift_ir", 64'(tap_state), 64'hA);
        for (int i = 0; i < int'(IR_W); i++) begin
            exp_q.push_back(i == 0);
            tick(i == int'(IR_W) - 1, op[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("ir_out_update", 64'(ir_out), 64'(op));
    endtask

    // From Run-Test/Idle: scan n DR bits and return to Run-Test/Idle.
    task automatic shift_dr(input int n, input logic [63:0] din, input logic [63:0] dexp);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(dexp[i]);
            tick(i == n - 1, din[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // Monitor: pops one expected TDO bit whenever the DUT drives TDO; also tallies strobes.
    initial begin
        logic e;
        forever begin
            @(negedge TCLK);
            if (tdo_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("tdo_unexpected_bit", 64'(TDO), 64'hx);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("tdo_bit%0d", tdo_idx), 64'(TDO), 64'(e));
                end
                tdo_idx++;
            end
            if (bsr_capture === 1'b1) cap_cnt++;
            if (bsr_shift === 1'b1)   shf_cnt++;
            if (bsr_update === 1'b1)  upd_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, s0, u0;
        logic [63:0] din;
        TRST = 1'b0;
        TMS  = 1'b1;
        TDI  = 1'b0;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("rst_state", 64'(tap_state), 64'hF);
        check("rst_ir_out", 64'(ir_out), 64'(RESET_IR));
        check("rst_tdo_en", 64'(tdo_en), 64'h0);
        check("rst_tdo", 64'(TDO), 64'h0);
        check("rst_strobes", 64'({bsr_capture, bsr_shift, bsr_update}), 64'h0);

        TRST = 1'b1;
        tick(1'b0, 1'b0);
        check("state_rti", 64'(tap_state), 64'hC);

        // Reset instruction DR read
        din = 64'h0000_0000_DEAD_BEEF;
`ifdef JTAG_IDCODE_EN
        shift_dr(32, din, 64'(IDCODE_VAL));
`else
        shift_dr(32, din, {din[62:0], 1'b0});
`endif

        // Bypass for all-ones and for an unassigned opcode
        shift_ir(4'hF);
        check("bsr_mode_bypass", 64'(bsr_mode), 64'h0);
        shift_dr(9, 64'h0A5, 64'h14A);
        shift_ir(4'h7);
        shift_dr(9, 64'h0A5, 64'h14A);

        // IDCODE opcode
        shift_ir(4'h2);
`ifdef JTAG_IDCODE_EN
        shift_dr(32, din, 64'(IDCODE_VAL));
`else
        shift_dr(32, din, {din[62:0], 1'b0});
`endif

        // EXTEST: BSR strobes and TDO from bsr_tdo
        shift_ir(4'h0);
        check("bsr_mode_extest", 64'(bsr_mode), 64'h1);
        c0 = cap_cnt; s0 = shf_cnt; u0 = upd_cnt;
        shift_dr(int'(BSR_LEN), 64'h0, CAP_PAT);
        check("extest_capture_cycles", 64'(cap_cnt - c0), 64'd1);
        check("extest_shift_cycles", 64'(shf_cnt - s0), 64'd36);
        check("extest_update_cycles", 64'(upd_cnt - u0), 64'd1);

        // Strobes stay low when BSR is not selected
        shift_ir(4'hF);
        c0 = cap_cnt; s0 = shf_cnt; u0 = upd_cnt;
        shift_dr(9, 64'h1C3, 64'h386);
        check("bypass_strobe_cycles", 64'((cap_cnt - c0) + (shf_cnt - s0) + (upd_cnt - u0)), 64'd0);

        // Pause-DR holds the bypass bit, then TMS escape to reset
        shift_ir(4'h7);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        exp_q.push_back(1'b0);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("state_pause_dr", 64'(tap_state), 64'h3);
        check("pause_tdo_en", 64'(tdo_en), 64'h0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        exp_q.push_back(1'b1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        check("escape_state", 64'(tap_state), 64'hF);
        check("escape_ir_out", 64'(ir_out), 64'(RESET_IR));

        // TRST asserted while in Shift-DR
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("state_shift_dr", 64'(tap_state), 64'h2);
`ifdef JTAG_IDCODE_EN
        exp_q.push_back(IDCODE_VAL[0]);
`else
        exp_q.push_back(1'b0);
`endif
        TRST = 1'b0;
        tick(1'b0, 1'b1);
        check("midshift_rst_state", 64'(tap_state), 64'hF);
        check("midshift_rst_tdo_en", 64'(tdo_en), 64'h0);
        check("midshift_rst_tdo", 64'(TDO), 64'h0);
        check("midshift_rst_ir_out", 64'(ir_out), 64'(RESET_IR));
        TRST = 1'b1;
        tick(1'b1, 1'b0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
